// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   This block shares one single-port synchronous RAM between two requesters:
//   the CPU port and the program loader. A new arbitration decision is made
//   every cycle, and requesters use a req/gnt handshake. The winner is routed
//   onto the RAM port. Read data goes back to the requester that issued the
//   read, one cycle after the read was accepted. A consecutive-grant counter
//   limits how long one requester can hold the RAM while the other is waiting.
//
// Build option:
//   ARB_ROUND_ROBIN_EN
//     defined   : contested cycles alternate between requesters, starting
//                 with the CPU.
//     undefined : the CPU has fixed priority. The loader wins a contested
//                 cycle only through the starvation override.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/we/addr/wdata  -> cpu_gnt  CPU request and combinational grant
//   cpu_rvalid, cpu_rdata              CPU read return (rdata is 0 when idle)
//   ldr_req/we/addr/wdata  -> ldr_gnt  loader request and grant
//   ldr_rvalid, ldr_rdata              loader read return
//   mem_en/we/addr/wdata               RAM access driven by the winner
//   mem_rdata                          RAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // rd_owner | meaning
    // ---------+--------------------------------------------------------
    // OWN_NONE | no read in flight, both rvalid outputs low
    // OWN_CPU  | read accepted last edge belongs to the CPU
    // OWN_LDR  | read accepted last edge belongs to the loader
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    typedef enum logic {
        WIN_CPU = 1'b0,
        WIN_LDR = 1'b1
    } win_t;

    logic [2:0] r_consec;
    logic [2:0] w_consec_nxt;
    win_t       r_last;
    win_t       w_last_nxt;
    win_t       w_win;
    owner_t     r_rd_owner;
    owner_t     w_rd_owner_nxt;

    logic       w_contested;
    logic       w_starve;
    logic       w_policy_ldr;
    logic       w_pick_ldr;
    logic       w_any_gnt;

    assign w_contested = cpu_req & ldr_req;
    assign w_starve    = w_contested && (r_consec == 3'(MAX_CONSEC));

`ifdef ARB_ROUND_ROBIN_EN
    // r_last resets to the CPU. Without this flag, the first contested cycle
    // would go to the loader. The flag makes the CPU win that first contest.
    logic r_rr_primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_primed <= 1'b0;
        end else if (w_contested) begin
            r_rr_primed <= 1'b1;
        end
    end

    assign w_policy_ldr = r_rr_primed && (r_last == WIN_CPU);
`else
    assign w_policy_ldr = 1'b0;
`endif

    // Starvation override: when consec has reached the limit, the requester
    // that did not win last time gets this contested cycle.
    assign w_pick_ldr = w_starve ? (r_last == WIN_CPU) : w_policy_ldr;

    // Grants are forced low while reset is asserted, even with requests high.
    assign cpu_gnt   = rst_n && cpu_req && (!ldr_req || !w_pick_ldr);
    assign ldr_gnt   = rst_n && ldr_req && (!cpu_req ||  w_pick_ldr);
    assign w_any_gnt = cpu_gnt | ldr_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_consec   <= 3'd0;
            r_last     <= WIN_CPU;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_consec   <= w_consec_nxt;
            r_last     <= w_last_nxt;
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_consec_nxt   = 3'd0;
        w_last_nxt     = r_last;
        w_win          = WIN_CPU;
        w_rd_owner_nxt = OWN_NONE;

        if (w_any_gnt) begin
            w_win      = ldr_gnt ? WIN_LDR : WIN_CPU;
            w_last_nxt = w_win;
            if (w_contested && (w_win == r_last)) begin
                w_consec_nxt = r_consec + 3'd1;
            end else if (w_contested) begin
                w_consec_nxt = 3'd1;
            end
        end

        if (cpu_gnt && !cpu_we) begin
            w_rd_owner_nxt = OWN_CPU;
        end else if (ldr_gnt && !ldr_we) begin
            w_rd_owner_nxt = OWN_LDR;
        end
    end

    assign mem_en    = w_any_gnt;
    assign mem_we    = cpu_gnt ? cpu_we    : (ldr_gnt ? ldr_we    : 1'b0);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : '0);

    assign cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign ldr_rvalid = (r_rd_owner == OWN_LDR);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAXC = 4;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0]  cpu_addr, ldr_addr;
    logic [15:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [15:0] cpu_rdata, ldr_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_CONSEC(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Contents of a RAM word that has never been written.
    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a, ~a};
    endfunction

    // RAM fixture: single port, synchronous read.
    logic [15:0]  ram [256];
    logic [255:0] ram_written = '0;
    logic [15:0]  ram_q = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]         <= mem_wdata;
                ram_written[mem_addr] <= 1'b1;
            end else begin
                ram_q <= ram_written[mem_addr] ? ram[mem_addr] : pat(mem_addr);
            end
        end
    end
    assign mem_rdata = ram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic cg, input logic lg,
                           input logic crv, input logic [15:0] crd,
                           input logic lrv, input logic [15:0] lrd,
                           input logic men, input logic mwe,
                           input logic [7:0] ma, input logic [15:0] mwd);
        chk({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'(cg));
        chk({tag, ".ldr_gnt"},    32'(ldr_gnt),    32'(lg));
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(crv));
        chk({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'(crd));
        chk({tag, ".ldr_rvalid"}, 32'(ldr_rvalid), 32'(lrv));
        chk({tag, ".ldr_rdata"},  32'(ldr_rdata),  32'(lrd));
        chk({tag, ".mem_en"},     32'(mem_en),     32'(men));
        chk({tag, ".mem_we"},     32'(mem_we),     32'(mwe));
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'(ma));
        chk({tag, ".mem_wdata"},  32'(mem_wdata),  32'(mwd));
    endtask

    // Reference model state. Winner codes: 0 = none, 1 = cpu, 2 = ldr.
    bit          hist_cont[$];
    int          hist_win[$];
    int          m_last;
    bit          m_seen_cont;
    logic [15:0] mm [256];

    // Number of cycles just before this one in which both requesters asked
    // and the same requester won every time.
    function automatic int trailing_run();
        int i;
        int run;
        int w;
        run = 0;
        if (hist_win.size() == 0) return 0;
        i = hist_win.size() - 1;
        w = hist_win[i];
        while (i >= 0 && hist_cont[i] && hist_win[i] == w) begin
            run++;
            i--;
        end
        return run;
    endfunction

    function automatic int model_winner(input bit cr, input bit lr);
        if (!cr && !lr) return 0;
        if (cr && !lr)  return 1;
        if (!cr && lr)  return 2;
        if (trailing_run() == MAXC) return 3 - m_last;
`ifdef ARB_ROUND_ROBIN_EN
        if (!m_seen_cont) return 1;
        return 3 - m_last;
`else
        return 1;
`endif
    endfunction

    typedef struct {
        bit cr;
        bit lr;
        bit cg;
        bit lg;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int          prev;
        int          w;
        int          exp_owner;
        logic [15:0] exp_rd;
        bit          c_pend, c_we, l_pend, l_we;
        logic [7:0]  c_addr, l_addr;
        logic [15:0] c_wd, l_wd;

        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            tbl[i] = '{1, 1, (i % 2) == 0, (i % 2) == 1};
`else
            tbl[i] = '{1, 1, (i % 5) != 4, (i % 5) == 4};
`endif
        end
        tbl[10] = '{1, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 1};
        tbl[12] = '{0, 0, 0, 0};
        tbl[13] = '{1, 1, 1, 0};

        // Hold reset with both requesters asking: every output must stay 0.
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'hBEEF;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h44; ldr_wdata = 16'hCAFE;
        repeat (3) @(negedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 8'h0, 16'h0);
        rst_n = 1'b1;
        cpu_req = 1'b0; ldr_req = 1'b0;

        // Arbitration vectors: reads only, returns checked one row later.
        prev = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            cpu_req = tbl[i].cr; ldr_req = tbl[i].lr;
            cpu_we = 1'b0; ldr_we = 1'b0;
            cpu_addr = 8'h10; ldr_addr = 8'h20;
            cpu_wdata = 16'hAAAA; ldr_wdata = 16'h5555;
            #1;
            chk_all($sformatf("tbl%0d", i), tbl[i].cg, tbl[i].lg,
                    prev == 1, (prev == 1) ? pat(8'h10) : 16'h0,
                    prev == 2, (prev == 2) ? pat(8'h20) : 16'h0,
                    tbl[i].cg | tbl[i].lg, 1'b0,
                    tbl[i].cg ? 8'h10 : (tbl[i].lg ? 8'h20 : 8'h0),
                    tbl[i].cg ? 16'hAAAA : (tbl[i].lg ? 16'h5555 : 16'h0));
            prev = tbl[i].cg ? 1 : (tbl[i].lg ? 2 : 0);
        end
        @(negedge clk);
        cpu_req = 1'b0; ldr_req = 1'b0;
        #1;
        chk_all("tbl_tail", 0, 0, 1, pat(8'h10), 0, 16'h0, 0, 0, 8'h0, 16'h0);

        // CPU alone: write 0x0010 to 0x04, then read it back.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h04; cpu_wdata = 16'h0010;
        #1;
        chk_all("cpu_wr", 1, 0, 0, 16'h0, 0, 16'h0, 1, 1, 8'h04, 16'h0010);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk_all("cpu_rd", 1, 0, 0, 16'h0, 0, 16'h0, 1, 0, 8'h04, 16'h0010);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk_all("cpu_ret", 0, 0, 1, 16'h0010, 0, 16'h0, 0, 0, 8'h0, 16'h0);

        // Same-address collision after a fresh reset: CPU read vs loader write.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h08; cpu_wdata = 16'h0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h08; ldr_wdata = 16'h1234;
        #1;
        chk_all("col_c", 1, 0, 0, 16'h0, 0, 16'h0, 1, 0, 8'h08, 16'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk_all("col_l", 0, 1, 1, pat(8'h08), 0, 16'h0, 1, 1, 8'h08, 16'h1234);
        @(negedge clk);
        ldr_req = 1'b0; cpu_req = 1'b1;
        #1;
        chk_all("col_rd", 1, 0, 0, 16'h0, 0, 16'h0, 1, 0, 8'h08, 16'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk_all("col_ret", 0, 0, 1, 16'h1234, 0, 16'h0, 0, 0, 8'h0, 16'h0);

        // Reset lands in the cycle after an accepted loader read.
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
        #1;
        chk("rstmid.ldr_gnt", 32'(ldr_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
        #1;
        chk_all("rstmid0", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 8'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rstmid1", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 8'h0, 16'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk_all("rstmid2", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 8'h0, 16'h0);
        end

        // Randomized traffic against the model, starting from a fresh reset.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mm[i] = pat(8'(i));
        mm[8'h04] = 16'h0010;
        mm[8'h08] = 16'h1234;
        hist_cont.delete();
        hist_win.delete();
        m_last = 1;
        m_seen_cont = 1'b0;
        exp_owner = 0;
        exp_rd = 16'h0;
        c_pend = 0; l_pend = 0; c_we = 0; l_we = 0;
        c_addr = 0; l_addr = 0; c_wd = 0; l_wd = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!c_pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    c_pend = 1; c_we = 1'($urandom_range(0, 1));
                    c_addr = 8'($urandom_range(0, 15)); c_wd = 16'($urandom);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                c_pend = 0;
            end
            if (!l_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    l_pend = 1; l_we = 1'($urandom_range(0, 1));
                    l_addr = 8'($urandom_range(0, 15)); l_wd = 16'($urandom);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                l_pend = 0;
            end
            cpu_req = c_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
            ldr_req = l_pend; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wd;
            #1;
            w = model_winner(c_pend, l_pend);
            chk_all($sformatf("rand%0d", cyc), w == 1, w == 2,
                    exp_owner == 1, (exp_owner == 1) ? exp_rd : 16'h0,
                    exp_owner == 2, (exp_owner == 2) ? exp_rd : 16'h0,
                    w != 0,
                    (w == 1) ? c_we : ((w == 2) ? l_we : 1'b0),
                    (w == 1) ? c_addr : ((w == 2) ? l_addr : 8'h0),
                    (w == 1) ? c_wd : ((w == 2) ? l_wd : 16'h0));

            hist_cont.push_back(c_pend && l_pend);
            hist_win.push_back(w);
            if (c_pend && l_pend) m_seen_cont = 1'b1;
            exp_owner = 0;
            if (w == 1) begin
                m_last = 1;
                if (c_we) mm[c_addr] = c_wd;
                else begin exp_owner = 1; exp_rd = mm[c_addr]; end
                c_pend = 0;
            end else if (w == 2) begin
                m_last = 2;
                if (l_we) mm[l_addr] = l_wd;
                else begin exp_owner = 2; exp_rd = mm[l_addr]; end
                l_pend = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 256×16 synchronous RAM behind the Simple RISC Machine between two requesters: the CPU load/store/fetch port and the program loader. The loader fills memory before or while the CPU runs from `start_pc`. The block performs per-cycle arbitration with a req/gnt handshake. It routes the winner onto the RAM port, returns read data to the correct requester one cycle later, and bounds starvation with a consecutive-grant counter.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM word width.
- `MAX_CONSEC`, 4: maximum consecutive contested grants to one requester (1..7).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req`, `cpu_we` in 1: CPU request and write enable.
- `cpu_addr` in `ADDR_W`, `cpu_wdata` in `DATA_W`: CPU address and write data.
- `cpu_gnt` out 1: CPU request accepted this cycle.
- `cpu_rvalid` out 1, `cpu_rdata` out `DATA_W`: CPU read return.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`: loader request, same meaning as the CPU set.
- `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: loader grant and read return.
- `mem_en`, `mem_we` out 1: RAM access enable and write enable.
- `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`: RAM address and write data.
- `mem_rdata` in `DATA_W`: RAM read data, valid the cycle after a read is enabled.

## Operation
- Transaction acceptance: a transaction is accepted on the edge ending a cycle with `x_req && x_gnt`.
- Grants: `cpu_gnt` and `ldr_gnt` are combinational from the current requests and registered arbiter state. At most one grant is high per cycle. No grant is given without a request.
- Uncontested cycle: the sole requester wins.
- Contested cycle (both request): the winner is chosen by the priority policy (see Configuration), subject to the starvation override.
- Starvation counter `consec` (3 bits) and last-winner register `last`:
  - Contested cycle, same winner as `last`: `consec` increments.
  - Otherwise: `consec` is set to 1 if contested, 0 if not.
  - When `consec == MAX_CONSEC` and the next cycle is contested, the other requester wins regardless of policy.
- RAM routing: `mem_en = cpu_gnt | ldr_gnt`. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner and are 0 when idle.
- Read return: the registered `rd_owner` (none/cpu/ldr) captures the owner of each accepted read. In the following cycle, that requester's `rvalid` is 1 and its `rdata` is `mem_rdata`.
- Idle return: `rdata` outputs are 0 whenever their `rvalid` is low.
- Writes produce no `rvalid`.
- Back-to-back accepted reads by either requester are supported: one return per cycle, in order.
- Requesters hold `req`/`we`/`addr`/`wdata` stable until granted. Dropping `req` before grant withdraws the request, which is legal.

## Timing
- Reset (async, `rst_n` low):
  - `consec` = 0, `last` = cpu, `rd_owner` = none.
  - All outputs are 0, including grants (forced low while `rst_n` is low).
- Read latency: accept at edge N → `rvalid` high during cycle N+1 only.
- Write: committed by the RAM on the accepting edge. A read of the same address accepted on the next edge returns the new data.
- Same-cycle CPU read and loader write to the same address: only the winner proceeds. The loser retries next cycle, so ordering follows grant order.
- Reset asserted between accept and return: the pending `rvalid` is discarded and never issued.
- Throughput: one RAM access per cycle, with no bubble on grant switches.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: contested cycles go to the requester that is not `last`. The first contested cycle after reset goes to the CPU. The starvation counter is present but never fires for `MAX_CONSEC` ≥ 2.
  - Undefined: fixed priority, CPU wins contested cycles, and the loader is served only through the starvation override.

## Test plan
- Reset: hold `rst_n` low with both `req` high → all grants, `rvalid`, `rdata` and `mem_*` are 0. After release, `consec` = 0 and the first contested grant goes to the CPU.
- CPU alone writes 0x0010 to address 0x04, then reads 0x04 → `cpu_gnt` high on both cycles, and `cpu_rvalid`=1 with `cpu_rdata`=0x0010 on the cycle after the read. `ldr_rvalid` stays 0.
- Fixed priority (macro undefined), `MAX_CONSEC`=4, both reading continuously → grant sequence C,C,C,C,L,C,C,C,C,L. Each `rvalid` appears on its owner one cycle after its grant.
- `ARB_ROUND_ROBIN_EN` defined, both requesting → grants C,L,C,L,…, with no cycle lacking a grant.
- Loader writes 0x1234 to address 0x08 and the CPU reads 0x08 in the same cycle, fixed priority → CPU granted first and returns the old value. Loader is granted the next cycle. A subsequent CPU read returns 0x1234.
- Assert `rst_n` in the cycle after an accepted loader read → `ldr_rvalid` never pulses, and all outputs are 0 until the next accepted request.
